// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: operation codes, FSM states
// and the default operand width, so the decoder and the unit agree on encodings.
package mul_div_unit_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_NOP7  = 3'd7
  } mdOp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdState_e;

  function automatic logic isDivOp(input mdOp_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isMulOp(input mdOp_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic isSignedOp(input mdOp_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_iter_core.sv
// Iteration datapath: one shift-add multiply step or one restoring divide step
// per cycle on a 2*WIDTH accumulator, plus the iteration counter.
module md_iter_core
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               divMode,
  input  logic [WIDTH-1:0]   loadAcc,
  input  logic [WIDTH-1:0]   loadOpnd,
  output logic [2*WIDTH-1:0] acc,
  output logic               lastIter
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   opnd;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     remShift;
  logic [WIDTH+1:0]   divDiff;

  // Multiply: low half holds the unconsumed multiplier bits, high half the
  // running partial product; the carry of the add shifts into the product.
  // Divide: high half is the partial remainder, low half fills with quotient bits.
  always_comb begin
    addend   = acc[0] ? opnd : '0;
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    remShift = acc[2*WIDTH-1:WIDTH-1];
    divDiff  = {1'b0, remShift} - {2'b00, opnd};
    accNext  = {mulSum, acc[WIDTH-1:1]};
    if (divMode) begin
      if (!divDiff[WIDTH+1])
        accNext = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        accNext = {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  assign lastIter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      opnd <= '0;
      cnt  <= '0;
    end else if (load) begin
      acc  <= {{WIDTH{1'b0}}, loadAcc};
      opnd <= loadOpnd;
      cnt  <= '0;
    end else if (step) begin
      acc  <= accNext;
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage iterative multiply/divide unit owning HI/LO: operand sign handling,
// control FSM and result write-back around the md_iter_core datapath.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] opr1,
  input  logic [WIDTH-1:0] opr2,
  input  logic [2:0]       mdOp,
  input  logic             start,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] absVal(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] negIf(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negIfWide(input logic [2*WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  mdState_e            state;
  mdOp_e               opCode;
  logic signed [WIDTH-1:0] opr1S;
  logic signed [WIDTH-1:0] opr2S;
  logic                opDiv;
  logic                opMul;
  logic                opSigned;
  logic                divByZero;
  logic                loadCore;
  logic                stepCore;
  logic [WIDTH-1:0]    mag1;
  logic [WIDTH-1:0]    mag2;
  logic [2*WIDTH-1:0]  coreAcc;
  logic                coreLast;
  logic                curDiv;
  logic                negLo;
  logic                negHi;

  assign opCode    = mdOp_e'(mdOp);
  assign opr1S     = opr1;
  assign opr2S     = opr2;
  assign opDiv     = isDivOp(opCode);
  assign opMul     = isMulOp(opCode);
  assign opSigned  = isSignedOp(opCode);
  assign divByZero = opDiv && (opr2 == '0);
  assign mag1      = opSigned ? absVal(opr1S) : opr1;
  assign mag2      = opSigned ? absVal(opr2S) : opr2;
  assign loadCore  = (state == ST_IDLE) && start && !flush && (opMul || (opDiv && !divByZero));
  assign stepCore  = (state == ST_CALC) && !flush;

  // Divide keeps the dividend in the accumulator and the divisor as operand;
  // multiply keeps the multiplier in the accumulator.
  md_iter_core #(.WIDTH(WIDTH)) uCore (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (loadCore),
    .step     (stepCore),
    .divMode  (curDiv),
    .loadAcc  (opDiv ? mag1 : mag2),
    .loadOpnd (opDiv ? mag2 : mag1),
    .acc      (coreAcc),
    .lastIter (coreLast)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      curDiv  <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
    end else begin
      done    <= 1'b0;
      divZero <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              case (opCode)
                MD_MTHI: hi <= opr1;
                MD_MTLO: lo <= opr1;
                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                  if (divByZero) begin
                    divZero <= 1'b1;
                  end else begin
                    state  <= ST_CALC;
                    busy   <= 1'b1;
                    curDiv <= opDiv;
                    negLo  <= opSigned && (opr1[WIDTH-1] ^ opr2[WIDTH-1]);
                    negHi  <= opSigned && opDiv && opr1[WIDTH-1];
                  end
                end
                default: ;
              endcase
            end
          end
          ST_CALC: begin
            if (coreLast)
              state <= ST_FIX;
          end
          ST_FIX: begin
            // Remainder follows the dividend sign; quotient/product follow the XOR.
            if (curDiv) begin
              lo <= negIf(coreAcc[WIDTH-1:0], negLo);
              hi <= negIf(coreAcc[2*WIDTH-1:WIDTH], negHi);
            end else begin
              {hi, lo} <= negIfWide(coreAcc, negLo);
            end
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  startWhileBusy: assert property (@(posedge clk) disable iff (!rst_n) !(start && busy))
    else $error("mul_div_unit: start issued while busy");
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes reference results into a
// queue, a negedge monitor pops and compares them whenever done/divZero pulses.
module tb_mul_div_unit;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] opr1, opr2;
  logic [2:0]  mdOp;
  logic        start, flush;
  logic        busy, done, divZero;
  logic [31:0] hi, lo;

  typedef struct {
    bit          isDz;
    logic [31:0] h;
    logic [31:0] l;
  } sbEntry_t;

  sbEntry_t    sbQ[$];
  int          nCompared = 0;
  int          nMismatch = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .opr1    (opr1),
    .opr2    (opr2),
    .mdOp    (mdOp),
    .start   (start),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .divZero (divZero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference results straight from integer arithmetic on 64-bit values.
  function automatic logic [63:0] refCalc(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU:  return {32'(a % b), 32'(a / b)};
      default:  return 64'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    sbEntry_t e;
    if (rst_n === 1'b1) begin
      if (done === 1'b1 || divZero === 1'b1) begin
        if (sbQ.size() == 0) begin
          nCompared++;
          nMismatch++;
          $display("FAIL unexpected pulse: done=%b divZero=%b with empty scoreboard", done, divZero);
        end else begin
          e = sbQ.pop_front();
          check("pulse kind divZero", 64'(divZero), 64'(e.isDz));
          check("result hi", 64'(hi), 64'(e.h));
          check("result lo", 64'(lo), 64'(e.l));
        end
      end
    end
  end

  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    int n;
    sbEntry_t e;
    r = refCalc(op, a, b);
    @(negedge clk);
    mdOp = op; opr1 = a; opr2 = b; start = 1'b1;
    if (op == OP_MTHI || op == OP_MTLO) begin
      if (op == OP_MTHI) mHi = a; else mLo = a;
      @(negedge clk);
      start = 1'b0;
      check("mt hi", 64'(hi), 64'(mHi));
      check("mt lo", 64'(lo), 64'(mLo));
      check("mt busy", 64'(busy), 64'd0);
    end else if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) begin
      e.isDz = 1'b1; e.h = mHi; e.l = mLo;
      sbQ.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("divZero pulse", 64'(divZero), 64'd1);
      check("divZero busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("divZero busy later", 64'(busy), 64'd0);
      check("divZero no done", 64'(done), 64'd0);
    end else if (op >= OP_MULT && op <= OP_DIVU) begin
      mHi = r[63:32]; mLo = r[31:0];
      e.isDz = 1'b0; e.h = mHi; e.l = mLo;
      sbQ.push_back(e);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        n++;
        @(negedge clk);
      end
      check("busy cycles", 64'(n), 64'd33);
      check("done timing", 64'(done), 64'd1);
    end else begin
      @(negedge clk);
      start = 1'b0;
      check("nop busy", 64'(busy), 64'd0);
      check("nop hi", 64'(hi), 64'(mHi));
      check("nop lo", 64'(lo), 64'(mLo));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", nCompared);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0]  op;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; mdOp = OP_NOP; opr1 = '0; opr2 = '0;
    repeat (2) @(negedge clk);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset divZero", 64'(divZero), 64'd0);
    rst_n = 1'b1;

    runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu max hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu max lo", 64'(lo), 64'h0000_0001);
    runOp(OP_MULT, 32'hFFFF_FFF9, 32'd3);
    check("mult -7*3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div -7/2 lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check("div -7/2 hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    runOp(OP_DIVU, 32'd100, 32'd7);
    check("divu 100/7 lo", 64'(lo), 64'd14);
    check("divu 100/7 hi", 64'(hi), 64'd2);
    runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div minint lo", 64'(lo), 64'h8000_0000);
    check("div minint hi", 64'(hi), 64'd0);

    runOp(OP_MTHI, 32'h11, 32'd0);
    runOp(OP_MTLO, 32'h22, 32'd0);
    runOp(OP_DIV, 32'd5, 32'd0);
    check("div0 hi kept", 64'(hi), 64'h11);
    check("div0 lo kept", 64'(lo), 64'h22);
    runOp(OP_NOP, 32'h1234, 32'h5678);
    runOp(3'd7, 32'h1234, 32'h5678);

    // Abort a multiply mid-flight.
    @(negedge clk);
    mdOp = OP_MULT; opr1 = 32'd1234; opr2 = 32'd5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy drop", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("flush hi kept", 64'(hi), 64'(mHi));
    check("flush lo kept", 64'(lo), 64'(mLo));
    runOp(OP_MTHI, 32'h0000_ABCD, 32'd0);
    check("mthi after flush", 64'(hi), 64'h0000_ABCD);
    check("mthi lo untouched", 64'(lo), 64'h22);

    // Flush suppresses a start in IDLE.
    @(negedge clk);
    mdOp = OP_MTLO; opr1 = 32'hDEAD; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush+mtlo lo", 64'(lo), 64'(mLo));
    check("flush+mtlo busy", 64'(busy), 64'd0);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        2: begin a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                 b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1; end
        3: begin a = -32'($urandom_range(1, 1000)); b = 32'($urandom_range(1, 50)); end
        default: ;
      endcase
      runOp(op, a, b);
    end

    // Asynchronous reset in the middle of a DIVU.
    @(negedge clk);
    mdOp = OP_DIVU; opr1 = 32'd1000000; opr2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst hi", 64'(hi), 64'd0);
    check("async rst lo", 64'(lo), 64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    mHi = '0; mLo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    runOp(OP_MULTU, 32'd3, 32'd4);
    check("multu 3*4 lo", 64'(lo), 64'd12);
    check("multu 3*4 hi", 64'(hi), 64'd0);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(sbQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit in the EX stage, alongside the ALU. It consumes the same opr1/opr2 operands and owns the HI/LO registers. The core issues MULT/MULTU/DIV/DIVU, MTHI and MTLO. The unit produces 64-bit products and quotient/remainder pairs over multiple cycles and asserts a stall while busy. hi/lo feed the EX result mux used by MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
opr1  input  WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO source
opr2  input  WIDTH  rt operand: multiplier / divisor
mdOp  input  3  0=NOP 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO, 7=NOP
start  input  1  issue strobe; mdOp/opr1/opr2 are valid when high
flush  input  1  abort in-flight op; HI/LO keep their previous values
busy  output  1  operation in flight; the pipeline stalls on any access while high
done  output  1  one-cycle pulse on the cycle after HI/LO update from MULT/DIV
divZero  output  1  one-cycle pulse: DIV/DIVU issued with opr2==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n low): state=IDLE; hi=0, lo=0, busy=0, done=0, divZero=0; all datapath registers 0. Reset mid-operation aborts the op immediately.
- States: IDLE, CALC, FIX.
- IDLE, start=1:
  - MTHI: hi<=opr1. MTLO: lo<=opr1. Single edge, busy stays 0, no done.
  - MULT/MULTU/DIV/DIVU with divisor nonzero: latch the magnitudes (abs for signed ops), the op, and the result sign bits. Iteration counter <= 0, go to CALC, busy=1 from the next cycle.
  - DIV/DIVU with opr2==0: stay IDLE, hi/lo unchanged, divZero pulses the next cycle, no done.
  - mdOp NOP or 7: ignored.
- start while busy=1: ignored. The stall makes this illegal; an assertion flags it.
- CALC: one iteration per cycle, exactly WIDTH cycles, counter 0..WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring; the 2*WIDTH remainder:quotient register shifts left, the remainder is trial-subtracted against the divisor, and the quotient bit is set on a non-negative result.
  - At counter==WIDTH-1, go to FIX.
- FIX (one cycle): apply signs, write hi/lo, return to IDLE.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: quotient negated if the signs differ; remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo=0x80000000, hi=0 (wraps, no trap).
  - Unsigned ops: no correction.
  - Writes: {hi,lo}<=product; lo<=quotient, hi<=remainder.
- Latency: start sampled at edge E0; CALC spans E1..E32; FIX writes hi/lo at E33. busy is high from after E0 until after E33. done is high for the cycle after E33. Issue-to-result is 33 cycles.
- flush: highest priority after reset. In CALC/FIX it returns to IDLE and clears busy; hi/lo are not written and no done. flush together with a start in IDLE suppresses the start, including MTHI/MTLO.
- hi/lo hold their values throughout CALC. Reads during busy return the old values; the stall prevents their use.
- MTHI/MTLO never write the other register.

Decomposition:
- Shared package: mdOp encodings (MD_NOP..MD_MTLO), state encoding, and the WIDTH default, so the decoder and this unit share constants.
- One natural sub-module, md_iter_core: the CALC datapath (accumulator/remainder register, adder/subtractor, counter). mul_div_unit keeps the FSM, sign handling and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done 33 cycles after issue; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT -7*3 and DIV -7/2 -> {hi,lo}=0xFFFFFFFF_FFFFFFEB; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 5/0 with hi=0x11, lo=0x22 -> divZero pulse next cycle, busy never asserts, hi/lo unchanged, no done.
- MULT issued, flush at cycle 10 -> busy drops next cycle, no done, hi/lo keep their pre-issue values; MTHI 0xABCD immediately after -> hi=0xABCD in one cycle, lo unchanged.
- rst_n low at cycle 20 of a DIVU -> hi=lo=0, busy=0 immediately (async); after release a new MULTU 3*4 -> lo=12, hi=0.
